// File: rtl/seq_mul_core.sv
// Sequential unsigned multiplier with valid/ready handshakes on both sides.
// ALGO selects repeated addition (b cycles) or shift-add (WIDTH_B cycles) at elaboration.
module seq_mul_core #(
  parameter int unsigned WIDTH_A = 3,
  parameter int unsigned WIDTH_B = 3,
  parameter int unsigned ALGO    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_A-1:0]           a,
  input  logic [WIDTH_B-1:0]           b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0]   product,
  output logic                         busy
);

  localparam int unsigned PW   = WIDTH_A + WIDTH_B;
  localparam int unsigned IDXW = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTH_A-1:0]  a_reg;
  logic [WIDTH_B-1:0]  b_reg;
  logic [WIDTH_B-1:0]  cnt;
  logic [IDXW-1:0]     idx;
  logic                last_step_c;
  logic                zero_op_c;

  assign zero_op_c = (a == '0) || (b == '0);

  // Final iteration of the RUN phase for the selected algorithm
  always_comb begin
    last_step_c = 1'b0;
    if (ALGO == 0) begin
      last_step_c = (cnt == WIDTH_B'(1));
    end else begin
      last_step_c = (idx == IDXW'(WIDTH_B - 1));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = zero_op_c ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step_c) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; handshake/status outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Operand capture and accumulation; product holds through DONE and the following IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      idx     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            cnt     <= b;
            idx     <= '0;
            product <= '0;
          end
        end
        RUN: begin
          if (ALGO == 0) begin
            product <= product + PW'(a_reg);
            cnt     <= cnt - WIDTH_B'(1);
          end else begin
            if (b_reg[idx]) begin
              product <= product + (PW'(a_reg) << idx);
            end
            idx <= idx + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
